// File: rtl/rs_pipe_carry_alu.sv
// Pipelined add/subtract unit: the carry chain is cut into SEG-bit segments,
// one register stage per segment, with a single global advance enable.
module rs_pipe_carry_alu #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [1:0]       op_i,
  input  logic             ci_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] y_o,
  output logic             co_o,
  output logic             ov_o,
  output logic             zero_o
);

  localparam int NSEG = WIDTH / SEG;

  logic             en_s;
  logic             bi_s;
  logic             c0_s;

  logic [WIDTH-1:0] a_q  [NSEG];
  logic [WIDTH-1:0] a_d  [NSEG];
  logic [WIDTH-1:0] bb_q [NSEG];
  logic [WIDTH-1:0] bb_d [NSEG];
  logic [WIDTH-1:0] y_q  [NSEG];
  logic [WIDTH-1:0] y_d  [NSEG];
  logic             c_q  [NSEG];
  logic             c_d  [NSEG];
  logic             z_q  [NSEG];
  logic             z_d  [NSEG];
  logic             v_q  [NSEG];
  logic             v_d  [NSEG];
  logic             ov_q;
  logic             ov_d;

  logic [WIDTH-1:0] src_a_s [NSEG];
  logic [WIDTH-1:0] src_b_s [NSEG];
  logic [WIDTH-1:0] src_y_s [NSEG];
  logic             src_c_s [NSEG];
  logic             src_z_s [NSEG];
  logic             src_v_s [NSEG];
  logic [SEG:0]     sum_s   [NSEG];

  // A stalled output freezes the whole pipe, bubbles included.
  assign en_s       = ~v_q[NSEG-1] | out_ready_i;
  assign in_ready_o = en_s;

  always_comb begin
    bi_s = 1'b0;
    c0_s = 1'b0;
    case (op_i)
      2'b00: begin
        bi_s = 1'b0;
        c0_s = 1'b0;
      end
      2'b01: begin
        bi_s = 1'b1;
        c0_s = 1'b1;
      end
      2'b10: begin
        bi_s = 1'b0;
        c0_s = ci_i;
      end
      2'b11: begin
        bi_s = 1'b1;
        c0_s = ci_i;
      end
      default: begin
        bi_s = 1'b0;
        c0_s = 1'b0;
      end
    endcase
  end

  // Stage k consumes what stage k-1 registered; stage 0 consumes the ports.
  always_comb begin
    src_a_s[0] = a_i;
    if (bi_s) begin
      src_b_s[0] = ~b_i;
    end else begin
      src_b_s[0] = b_i;
    end
    src_y_s[0] = {WIDTH{1'b0}};
    src_c_s[0] = c0_s;
    src_z_s[0] = 1'b1;
    src_v_s[0] = in_valid_i;
    for (int k = 1; k < NSEG; k++) begin
      src_a_s[k] = a_q[k-1];
      src_b_s[k] = bb_q[k-1];
      src_y_s[k] = y_q[k-1];
      src_c_s[k] = c_q[k-1];
      src_z_s[k] = z_q[k-1];
      src_v_s[k] = v_q[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k < NSEG; k++) begin
      sum_s[k] = {1'b0, src_a_s[k][k*SEG +: SEG]}
               + {1'b0, src_b_s[k][k*SEG +: SEG]}
               + {{SEG{1'b0}}, src_c_s[k]};
    end
  end

  always_comb begin
    a_d  = a_q;
    bb_d = bb_q;
    y_d  = y_q;
    c_d  = c_q;
    z_d  = z_q;
    v_d  = v_q;
    ov_d = ov_q;
    if (en_s) begin
      for (int k = 0; k < NSEG; k++) begin
        a_d[k]                = src_a_s[k];
        bb_d[k]               = src_b_s[k];
        y_d[k]                = src_y_s[k];
        y_d[k][k*SEG +: SEG]  = sum_s[k][SEG-1:0];
        c_d[k]                = sum_s[k][SEG];
        z_d[k]                = src_z_s[k] & (sum_s[k][SEG-1:0] == {SEG{1'b0}});
        v_d[k]                = src_v_s[k];
      end
      // The top segment's sum bit SEG-1 is the result sign.
      ov_d = (src_a_s[NSEG-1][WIDTH-1] == src_b_s[NSEG-1][WIDTH-1]) &&
             (sum_s[NSEG-1][SEG-1] != src_a_s[NSEG-1][WIDTH-1]);
    end else begin
      ov_d = ov_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NSEG; k++) begin
        a_q[k]  <= {WIDTH{1'b0}};
        bb_q[k] <= {WIDTH{1'b0}};
        y_q[k]  <= {WIDTH{1'b0}};
        c_q[k]  <= 1'b0;
        z_q[k]  <= 1'b0;
        v_q[k]  <= 1'b0;
      end
      ov_q <= 1'b0;
    end else begin
      a_q  <= a_d;
      bb_q <= bb_d;
      y_q  <= y_d;
      c_q  <= c_d;
      z_q  <= z_d;
      v_q  <= v_d;
      ov_q <= ov_d;
    end
  end

  assign out_valid_o = v_q[NSEG-1];
  assign y_o         = y_q[NSEG-1];
  assign co_o        = c_q[NSEG-1];
  assign zero_o      = z_q[NSEG-1];
  assign ov_o        = ov_q;

endmodule

// File: tb/tb_rs_pipe_carry_alu.sv
// Bench for rs_pipe_carry_alu: three configurations checked cycle by cycle
// against a full-width arithmetic reference and an in-order expectation queue.
module tb_rs_pipe_carry_alu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv_s [3];
  logic        or_s [3];
  logic        ci_s [3];
  logic        irdy_s [3];
  logic        ovld_s [3];
  logic        co_s [3];
  logic        ovf_s [3];
  logic        z_s [3];
  logic [1:0]  op_s [3];
  logic [31:0] a_s [3];
  logic [31:0] b_s [3];
  logic [31:0] y0;
  logic [7:0]  y1;
  logic [23:0] y2;

  rs_pipe_carry_alu #(.WIDTH(32), .SEG(8)) u_w32 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv_s[0]), .in_ready_o(irdy_s[0]),
    .a_i(a_s[0]), .b_i(b_s[0]), .op_i(op_s[0]), .ci_i(ci_s[0]),
    .out_valid_o(ovld_s[0]), .out_ready_i(or_s[0]), .y_o(y0),
    .co_o(co_s[0]), .ov_o(ovf_s[0]), .zero_o(z_s[0]));

  rs_pipe_carry_alu #(.WIDTH(8), .SEG(8)) u_w8 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv_s[1]), .in_ready_o(irdy_s[1]),
    .a_i(a_s[1][7:0]), .b_i(b_s[1][7:0]), .op_i(op_s[1]), .ci_i(ci_s[1]),
    .out_valid_o(ovld_s[1]), .out_ready_i(or_s[1]), .y_o(y1),
    .co_o(co_s[1]), .ov_o(ovf_s[1]), .zero_o(z_s[1]));

  rs_pipe_carry_alu #(.WIDTH(24), .SEG(4)) u_w24 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv_s[2]), .in_ready_o(irdy_s[2]),
    .a_i(a_s[2][23:0]), .b_i(b_s[2][23:0]), .op_i(op_s[2]), .ci_i(ci_s[2]),
    .out_valid_o(ovld_s[2]), .out_ready_i(or_s[2]), .y_o(y2),
    .co_o(co_s[2]), .ov_o(ovf_s[2]), .zero_o(z_s[2]));

  typedef struct {
    logic [31:0] y;
    logic        co;
    logic        ov;
    logic        z;
    int          acc;
  } exp_t;

  int   wid  [3] = '{32, 8, 24};
  int   nseg [3] = '{4, 1, 6};
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   chk_lat = 1'b1;
  logic prev_stall = 1'b0;
  logic [31:0] prev_y = 32'd0;
  exp_t q[$];
  exp_t last_e;

  function automatic logic [31:0] msk(int w);
    longint unsigned m;
    m = (64'd1 << w) - 64'd1;
    return 32'(m);
  endfunction

  function automatic logic [31:0] rnd(int d);
    return $urandom & msk(wid[d]);
  endfunction

  // Reference: whole-word arithmetic; overflow from the true signed sum.
  function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b,
                                 logic [1:0] op, logic ci, int acc);
    exp_t e;
    longint unsigned m, au, bu, full;
    longint sa, sb, ss, lim;
    logic c0;
    m  = (64'd1 << w) - 64'd1;
    au = {32'd0, a} & m;
    bu = {32'd0, b} & m;
    if (op[0]) bu = ~bu & m;
    if (op == 2'b00) c0 = 1'b0;
    else if (op == 2'b01) c0 = 1'b1;
    else c0 = ci;
    full = au + bu + {63'd0, c0};
    e.y  = 32'(full & m);
    e.co = ((full >> w) & 64'd1) != 64'd0;
    e.z  = (full & m) == 64'd0;
    lim  = longint'(64'd1 << (w - 1));
    sa   = (longint'(au) >= lim) ? longint'(au) - 2 * lim : longint'(au);
    sb   = (longint'(bu) >= lim) ? longint'(bu) - 2 * lim : longint'(bu);
    ss   = sa + sb + longint'(c0);
    e.ov = (ss >= lim) || (ss < -lim);
    e.acc = acc;
    return e;
  endfunction

  function automatic logic [31:0] yv(int d);
    if (d == 0) return y0;
    else if (d == 1) return {24'd0, y1};
    else return {8'd0, y2};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, sample 1 time unit later, advance.
  task automatic tick(int d, logic r, logic v, logic [31:0] a, logic [31:0] b,
                      logic [1:0] op, logic c, logic ordy, output logic acc);
    logic vld, irdy;
    logic [31:0] y;
    rst = r; iv_s[d] = v; a_s[d] = a; b_s[d] = b;
    op_s[d] = op; ci_s[d] = c; or_s[d] = ordy;
    #1;
    vld = ovld_s[d]; irdy = irdy_s[d]; y = yv(d);
    if (!r) chk("in_ready", irdy, !(vld && !ordy));
    if (prev_stall) chk("hold_y", y, prev_y);
    if (q.size() == 0) begin
      chk("spurious_valid", vld, 1'b0);
    end else begin
      if (chk_lat) chk("latency_valid", vld, (cyc - q[0].acc) >= nseg[d]);
      if (vld) begin
        chk("y", y, q[0].y);
        chk("co", co_s[d], q[0].co);
        chk("ov", ovf_s[d], q[0].ov);
        chk("zero", z_s[d], q[0].z);
        if (ordy) last_e = q.pop_front();
      end
    end
    acc = v && irdy && !r;
    if (acc) q.push_back(model(wid[d], a, b, op, c, cyc));
    if (r) q.delete();
    prev_stall = vld && !ordy && !r;
    prev_y = y;
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(int d);
    logic acc;
    int k = 0;
    while (q.size() != 0 && k < 60) begin
      tick(d, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b1, acc);
      k++;
    end
    chk("drain_empty", q.size(), 0);
    tick(d, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b1, acc);
  endtask

  task automatic beat(int d, logic [31:0] a, logic [31:0] b, logic [1:0] op, logic c);
    logic acc = 1'b0;
    int k = 0;
    while (!acc && k < 20) begin
      tick(d, 1'b0, 1'b1, a, b, op, c, 1'b1, acc);
      k++;
    end
    chk("beat_accept", acc, 1'b1);
    drain(d);
  endtask

  task automatic stream(int d, int n, bit stall);
    logic acc, c, ordy;
    logic [31:0] a, b;
    logic [1:0] op;
    int sent = 0;
    int k = 0;
    chk_lat = !stall;
    a = rnd(d); b = rnd(d); op = 2'($urandom_range(0, 3)); c = 1'($urandom_range(0, 1));
    while (sent < n && k < n * 4 + 20) begin
      ordy = stall ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      tick(d, 1'b0, 1'b1, a, b, op, c, ordy, acc);
      if (acc) begin
        sent++;
        a = rnd(d); b = rnd(d); op = 2'($urandom_range(0, 3)); c = 1'($urandom_range(0, 1));
      end
      k++;
    end
    chk("stream_sent", sent, n);
    drain(d);
    chk_lat = 1'b1;
  endtask

  initial begin
    logic acc;
    for (int d = 0; d < 3; d++) begin
      iv_s[d] = 1'b0; or_s[d] = 1'b1; ci_s[d] = 1'b0;
      op_s[d] = 2'b00; a_s[d] = 32'd0; b_s[d] = 32'd0;
    end
    @(negedge clk);
    tick(0, 1'b1, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b1, acc);
    tick(0, 1'b1, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b1, acc);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_out_valid", ovld_s[d], 1'b0);
      chk("rst_in_ready", irdy_s[d], 1'b1);
      chk("rst_y", yv(d), 32'd0);
      chk("rst_co", co_s[d], 1'b0);
      chk("rst_ov", ovf_s[d], 1'b0);
      chk("rst_zero", z_s[d], 1'b0);
    end

    beat(0, 32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 1'b0);
    chk("t1_y", last_e.y, 32'h0); chk("t1_co", last_e.co, 1'b1);
    chk("t1_ov", last_e.ov, 1'b0); chk("t1_z", last_e.z, 1'b1);
    beat(0, 32'h8000_0000, 32'h0000_0001, 2'b01, 1'b0);
    chk("t2_y", last_e.y, 32'h7FFF_FFFF); chk("t2_co", last_e.co, 1'b1);
    chk("t2_ov", last_e.ov, 1'b1); chk("t2_z", last_e.z, 1'b0);
    beat(0, 32'h0000_0000, 32'h0000_0001, 2'b01, 1'b0);
    chk("t3_y", last_e.y, 32'hFFFF_FFFF); chk("t3_co", last_e.co, 1'b0);
    chk("t3_ov", last_e.ov, 1'b0);
    beat(0, 32'h0000_0001, 32'hFFFF_FFFF, 2'b10, 1'b1);
    chk("t4_y", last_e.y, 32'h1); chk("t4_co", last_e.co, 1'b1);
    beat(0, 32'd5, 32'd3, 2'b11, 1'b0);
    chk("t5_y", last_e.y, 32'h1); chk("t5_co", last_e.co, 1'b1);

    stream(0, 16, 1'b1);

    // Three beats in flight, then a one-cycle reset must flush them all.
    for (int i = 0; i < 3; i++)
      tick(0, 1'b0, 1'b1, rnd(0), rnd(0), 2'b00, 1'b0, 1'b1, acc);
    tick(0, 1'b1, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b1, acc);
    #1;
    chk("mid_rst_y", y0, 32'd0);
    chk("mid_rst_in_ready", irdy_s[0], 1'b1);
    for (int i = 0; i < 8; i++)
      tick(0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b1, acc);
    beat(0, 32'd2, 32'd3, 2'b00, 1'b0);
    chk("post_rst_y", last_e.y, 32'd5);

    beat(1, 32'h7F, 32'h01, 2'b00, 1'b0);
    chk("w8_y", last_e.y, 32'h80); chk("w8_ov", last_e.ov, 1'b1);
    chk("w8_co", last_e.co, 1'b0);
    beat(1, 32'h00, 32'h01, 2'b01, 1'b0);
    chk("w8_sub_y", last_e.y, 32'hFF); chk("w8_sub_co", last_e.co, 1'b0);
    stream(1, 30, 1'b0);
    stream(1, 12, 1'b1);

    beat(2, 32'hFF_FFFF, 32'h00_0001, 2'b00, 1'b0);
    chk("w24_y", last_e.y, 32'h0); chk("w24_co", last_e.co, 1'b1);
    chk("w24_z", last_e.z, 1'b1);
    stream(2, 30, 1'b0);
    stream(2, 12, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
